fc_argmax_sched: RTL
====================

// Module: fc_argmax_sched
// PURPOSE
//  Scheduler for the output-layer classifier. Accepts one 128-bit activation vector (32 x 4-bit signed),
//  time-shares a single per-class score unit across all N_CLASS classes (one class issued per accepted
//  request), tracks a running strict maximum, and returns class index + one-hot decision.
//  A class wins only if its score is strictly greater than every other class; any tie for the maximum
//  produces no winner (all-zero one-hot). Sits between the fc2 activation stage and the result sink.
// PARAMETERS
//  IN_W     128  activation vector width (32 lanes x ACT_W)
//  N_CLASS  10   number of output classes scored per vector
//  SCORE_W  9    signed score width returned by the score unit
//  IDX_W    4    class index width, $clog2(N_CLASS)
// PORTS
//  clk             in   1        single clock, all logic rising-edge
//  rst_n           in   1        synchronous, active-low reset
//  in_valid        in   1        activation vector offered
//  in_ready        out  1        scheduler can accept a vector (IDLE only)
//  in_vec          in   IN_W     activation vector
//  score_vec       out  IN_W     latched vector driven to the score unit, stable for the whole scan
//  score_req_valid out  1        request a score for class score_cls
//  score_req_ready in   1        score unit accepts request this cycle
//  score_cls       out  IDX_W    class index of current request
//  score_rsp_valid in   1        score response valid (in request order)
//  score_rsp       in   SCORE_W  signed score
//  out_valid       out  1        decision available
//  out_ready       in   1        sink takes decision
//  out_hit         out  1        1 = unique strict maximum found; 0 = tie for maximum
//  out_cls         out  IDX_W    winning class index (index of first maximum when out_hit=0)
//  out_onehot      out  N_CLASS  1<<out_cls when out_hit, else all zero
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): state=IDLE, in_ready=1 after reset, score_req_valid=0, score_cls=0,
//    out_valid=0, out_hit=0, out_cls=0, out_onehot=0, score_vec=0, counters/max/tie cleared.
//    Reset mid-scan abandons the vector; score unit shares rst_n, so no stale responses survive.
//  - FSM IDLE -> SCAN -> DONE -> IDLE.
//    IDLE: in_ready=1. in_valid&&in_ready: latch in_vec into score_vec, req_cnt=0, rsp_cnt=0, go SCAN.
//    SCAN: score_req_valid=1 while req_cnt<N_CLASS; score_cls=req_cnt; req_cnt++ on req_valid&&req_ready.
//          Each score_rsp_valid: rsp_cnt++; first response (rsp_cnt=0) loads max=score, idx=0, tie=0;
//          later: score>max (signed) -> max=score, idx=rsp_cnt, tie=0; score==max -> tie=1; else no change.
//          When the N_CLASS-th response is absorbed go DONE; outputs registered that same edge.
//    DONE: out_valid=1, outputs held stable until out_valid&&out_ready, then IDLE (in_ready=1 next cycle).
//  - Requests and responses may overlap (pipelined score unit); rsp_cnt never exceeds req_cnt.
//  - score_rsp_valid outside SCAN, or after N_CLASS responses, is ignored.
//  - in_ready=0 in SCAN and DONE: no back-to-back overlap; one vector in flight.
//  - Comparisons strictly signed, SCORE_W bits; no saturation (score unit guarantees range).
//  - Latency with score unit always ready and fixed latency L: out_valid at accept+N_CLASS+L+1 cycles.
// STRUCTURE
//  - fc_pkg: N_CLASS, SCORE_W, IDX_W, ACT_W=4, IN_W, typedef score_t (signed SCORE_W), cls_idx_t.
//  - Sub-module fc_argmax_track: running max/idx/tie register, inputs (clear, rsp_valid, score, idx).
//  - Top holds FSM, req/rsp counters, vector latch, output registers.
// TESTING
//  - Scores 0..9 = {3,-2,5,1,0,-7,4,2,-1,5}: tie at 5 -> out_hit=0, out_onehot=0, out_cls=2.
//  - Scores {-10,-3,-8,...,-9} max -3 unique -> out_hit=1, out_cls=1, out_onehot=10'b0000000010.
//  - Score unit L=1, always ready: in accepted at cycle 0 -> out_valid rises at cycle 12.
//  - score_req_ready toggled 1/0 each cycle, L=3: same decision as ready-always; score_cls 0..9 in order, no skips.
//  - out_ready=0 for 5 cycles in DONE: outputs stable, in_ready=0; in_ready=1 cycle after handshake.
//  - rst_n=0 after 4 responses: all outputs at reset values next cycle; new vector scans fresh, no stale max.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared sizing, types and helpers for the output-layer argmax scheduler.
package fc_pkg;

    localparam int N_CLASS = 10;
    localparam int SCORE_W = 9;
    localparam int IDX_W   = 4;
    localparam int ACT_W   = 4;
    localparam int N_LANE  = 32;
    localparam int IN_W    = N_LANE * ACT_W;

    typedef logic signed [SCORE_W-1:0] score_t;
    typedef logic [IDX_W-1:0]          cls_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    function automatic logic [N_CLASS-1:0] onehot_of(input cls_idx_t idx);
        return N_CLASS'(1) << idx;
    endfunction

endpackage

// File: rtl/fc_argmax_track.sv
// Running strict-maximum tracker. Exposes the post-update index/tie so the
// caller can register the final decision on the same edge as the last score.
module fc_argmax_track
    import fc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               rsp_valid,
    input  logic signed [SCORE_W-1:0] score,
    input  logic [IDX_W-1:0]   idx,
    output logic [IDX_W-1:0]   best_idx,
    output logic               tie
);

    score_t   max_reg, max_next;
    cls_idx_t idx_reg, idx_next;
    logic     tie_reg, tie_next;

    always_comb begin
        max_next = max_reg;
        idx_next = idx_reg;
        tie_next = tie_reg;
        if (clear) begin
            max_next = '0;
            idx_next = '0;
            tie_next = 1'b0;
        end else if (rsp_valid) begin
            // Class 0 seeds the maximum regardless of the stale register value.
            if (idx == '0 || score > max_reg) begin
                max_next = score;
                idx_next = idx;
                tie_next = 1'b0;
            end else if (score == max_reg) begin
                tie_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_reg <= '0;
            idx_reg <= '0;
            tie_reg <= 1'b0;
        end else begin
            max_reg <= max_next;
            idx_reg <= idx_next;
            tie_reg <= tie_next;
        end
    end

    assign best_idx = idx_next;
    assign tie      = tie_next;

endmodule

// File: rtl/fc_argmax_sched.sv
// Classifier scheduler: latches one activation vector, issues one score request
// per class to a shared score unit, and reports the unique strict maximum.
module fc_argmax_sched
    import fc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_vec,
    output logic [IN_W-1:0]    score_vec,
    output logic               score_req_valid,
    input  logic               score_req_ready,
    output logic [IDX_W-1:0]   score_cls,
    input  logic               score_rsp_valid,
    input  logic signed [SCORE_W-1:0] score_rsp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_hit,
    output logic [IDX_W-1:0]   out_cls,
    output logic [N_CLASS-1:0] out_onehot
);

    localparam cls_idx_t CNT_END = IDX_W'(N_CLASS);
    localparam cls_idx_t LAST    = IDX_W'(N_CLASS - 1);

    state_t   state_reg, state_next;
    cls_idx_t req_cnt_reg, rsp_cnt_reg;
    cls_idx_t trk_idx;
    logic     trk_tie;
    logic     accept, req_fire, rsp_take, last_rsp;

    assign accept   = in_valid && (state_reg == ST_IDLE);
    assign req_fire = score_req_valid && score_req_ready;
    // Responses arriving outside a scan or past the last class are dropped.
    assign rsp_take = (state_reg == ST_SCAN) && score_rsp_valid && (rsp_cnt_reg < CNT_END);
    assign last_rsp = rsp_take && (rsp_cnt_reg == LAST);
    assign score_cls = score_req_valid ? req_cnt_reg : '0;

    always_comb begin
        state_next      = state_reg;
        in_ready        = 1'b0;
        out_valid       = 1'b0;
        score_req_valid = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_SCAN;
            end
            ST_SCAN: begin
                score_req_valid = (req_cnt_reg < CNT_END);
                if (last_rsp) state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            req_cnt_reg <= '0;
            rsp_cnt_reg <= '0;
            score_vec   <= '0;
            out_hit     <= 1'b0;
            out_cls     <= '0;
            out_onehot  <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                score_vec   <= in_vec;
                req_cnt_reg <= '0;
                rsp_cnt_reg <= '0;
            end else begin
                if (req_fire) req_cnt_reg <= req_cnt_reg + 1'b1;
                if (rsp_take) rsp_cnt_reg <= rsp_cnt_reg + 1'b1;
            end
            if (last_rsp) begin
                out_hit    <= !trk_tie;
                out_cls    <= trk_idx;
                out_onehot <= trk_tie ? '0 : onehot_of(trk_idx);
            end
        end
    end

    fc_argmax_track u_track (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (accept),
        .rsp_valid (rsp_take),
        .score     (score_rsp),
        .idx       (rsp_cnt_reg),
        .best_idx  (trk_idx),
        .tie       (trk_tie)
    );

endmodule
